// File: rtl/lcd_pkg.sv
// Shared types and default timing for the HD44780 4-bit nibble driver.
// Defaults are tuned for a 50 MHz system clock.
package lcd_pkg;

   localparam int LCD_T_SETUP            = 2;
   localparam int LCD_T_E_HIGH           = 25;
   localparam int LCD_T_E_LOW            = 25;
   localparam int LCD_BUSY_TIMEOUT_POLLS = 4096;

   typedef enum logic [3:0] {
      IDLE,
      W_SETUP,
      W_EHIGH,
      W_ELOW,
      R_SETUP,
      R1_EHIGH,
      R1_ELOW,
      R2_EHIGH,
      R2_ELOW,
      DONE
   } lcd_drv_state_t;

   // Counter width that can hold maxVal-1, never narrower than one bit.
   function automatic int cntWidth(input int maxVal);
      return (maxVal > 1) ? $clog2(maxVal) : 1;
   endfunction

endpackage

// File: rtl/lcd_nibble_driver.sv
// Writes one nibble to an HD44780 in 4-bit mode with E strobe timing,
// optionally polling the busy flag before signalling completion.
module lcd_nibble_driver
   import lcd_pkg::*;
#(
   parameter int T_SETUP            = LCD_T_SETUP,
   parameter int T_E_HIGH           = LCD_T_E_HIGH,
   parameter int T_E_LOW            = LCD_T_E_LOW,
   parameter int BUSY_TIMEOUT_POLLS = LCD_BUSY_TIMEOUT_POLLS
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       sendCommand,
   input  logic [3:0] commandToSend,
   input  logic       commandToSendRs,
   input  logic       read_busy,
   output logic       commandDone,
   output logic       busyTimeout,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [3:0] LCD_DB_OUT,
   output logic       LCD_DB_OE,
   input  logic [3:0] LCD_DB_IN
);

   localparam int MAX_HL = (T_E_HIGH > T_E_LOW) ? T_E_HIGH : T_E_LOW;
   localparam int MAX_T  = (T_SETUP > MAX_HL) ? T_SETUP : MAX_HL;
   localparam int TW     = cntWidth(MAX_T);
   localparam int PW     = cntWidth(BUSY_TIMEOUT_POLLS + 1);

   localparam logic [TW-1:0] LD_SETUP  = TW'(T_SETUP - 1);
   localparam logic [TW-1:0] LD_EHIGH  = TW'(T_E_HIGH - 1);
   localparam logic [TW-1:0] LD_ELOW   = TW'(T_E_LOW - 1);
   localparam logic [PW-1:0] POLL_LIM  = PW'(BUSY_TIMEOUT_POLLS);

   lcd_drv_state_t  state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PW-1:0]   pollCnt_q, pollCnt_d;
   logic [3:0]      nibble_q, nibble_d;
   logic            rs_q, rs_d;
   logic            readBusy_q, readBusy_d;
   logic            bf_q, bf_d;
   logic            timeout_q, timeout_d;
   logic            done_q, done_d;
   logic            e_q, e_d;
   logic            lcdRs_q, lcdRs_d;
   logic            rw_q, rw_d;
   logic [3:0]      dbOut_q, dbOut_d;
   logic            oe_q, oe_d;

   logic            timerDone;
   logic [PW-1:0]   pollNext;
   logic            unusedDbIn;

   assign timerDone  = (timer_q == '0);
   assign pollNext   = pollCnt_q + PW'(1);
   assign unusedDbIn = ^LCD_DB_IN[2:0];

   // Every timed state reloads the single down-counter on entry and leaves when it reaches zero.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      pollCnt_d  = pollCnt_q;
      nibble_d   = nibble_q;
      rs_d       = rs_q;
      readBusy_d = readBusy_q;
      bf_d       = bf_q;
      timeout_d  = timeout_q;

      if (!timerDone) begin
         timer_d = timer_q - TW'(1);
      end

      case (state_q)
         IDLE: begin
            if (sendCommand) begin
               nibble_d   = commandToSend;
               rs_d       = commandToSendRs;
               readBusy_d = read_busy;
               state_d    = W_SETUP;
               timer_d    = LD_SETUP;
            end
         end
         W_SETUP: begin
            if (timerDone) begin
               state_d = W_EHIGH;
               timer_d = LD_EHIGH;
            end
         end
         W_EHIGH: begin
            if (timerDone) begin
               state_d = W_ELOW;
               timer_d = LD_ELOW;
            end
         end
         W_ELOW: begin
            if (timerDone) begin
               if (readBusy_q) begin
                  state_d = R_SETUP;
                  timer_d = LD_SETUP;
               end else begin
                  state_d = DONE;
                  timer_d = '0;
               end
            end
         end
         R_SETUP: begin
            if (timerDone) begin
               state_d = R1_EHIGH;
               timer_d = LD_EHIGH;
            end
         end
         R1_EHIGH: begin
            if (timerDone) begin
               bf_d    = LCD_DB_IN[3];
               state_d = R1_ELOW;
               timer_d = LD_ELOW;
            end
         end
         R1_ELOW: begin
            if (timerDone) begin
               state_d = R2_EHIGH;
               timer_d = LD_EHIGH;
            end
         end
         R2_EHIGH: begin
            if (timerDone) begin
               state_d = R2_ELOW;
               timer_d = LD_ELOW;
            end
         end
         R2_ELOW: begin
            if (timerDone) begin
               pollCnt_d = pollNext;
               if (bf_q && (pollNext < POLL_LIM)) begin
                  state_d = R1_EHIGH;
                  timer_d = LD_EHIGH;
               end else begin
                  if (bf_q) begin
                     timeout_d = 1'b1;
                  end
                  state_d = DONE;
                  timer_d = '0;
               end
            end
         end
         DONE: begin
            pollCnt_d = '0;
            state_d   = IDLE;
            timer_d   = '0;
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Pin values are decoded from the next state so the registered outputs line up with the state register.
   always_comb begin
      done_d  = 1'b0;
      e_d     = 1'b0;
      lcdRs_d = 1'b0;
      rw_d    = 1'b0;
      dbOut_d = '0;
      oe_d    = 1'b0;

      case (state_d)
         W_SETUP, W_ELOW: begin
            lcdRs_d = rs_d;
            dbOut_d = nibble_d;
            oe_d    = 1'b1;
         end
         W_EHIGH: begin
            lcdRs_d = rs_d;
            dbOut_d = nibble_d;
            oe_d    = 1'b1;
            e_d     = 1'b1;
         end
         R_SETUP, R1_ELOW, R2_ELOW: begin
            rw_d = 1'b1;
         end
         R1_EHIGH, R2_EHIGH: begin
            rw_d = 1'b1;
            e_d  = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         pollCnt_q  <= '0;
         nibble_q   <= '0;
         rs_q       <= 1'b0;
         readBusy_q <= 1'b0;
         bf_q       <= 1'b0;
         timeout_q  <= 1'b0;
         done_q     <= 1'b0;
         e_q        <= 1'b0;
         lcdRs_q    <= 1'b0;
         rw_q       <= 1'b0;
         dbOut_q    <= '0;
         oe_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pollCnt_q  <= pollCnt_d;
         nibble_q   <= nibble_d;
         rs_q       <= rs_d;
         readBusy_q <= readBusy_d;
         bf_q       <= bf_d;
         timeout_q  <= timeout_d;
         done_q     <= done_d;
         e_q        <= e_d;
         lcdRs_q    <= lcdRs_d;
         rw_q       <= rw_d;
         dbOut_q    <= dbOut_d;
         oe_q       <= oe_d;
      end
   end

   assign commandDone = done_q;
   assign busyTimeout = timeout_q;
   assign LCD_E       = e_q;
   assign LCD_RS      = lcdRs_q;
   assign LCD_RW      = rw_q;
   assign LCD_DB_OUT  = dbOut_q;
   assign LCD_DB_OE   = oe_q;

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Bench for lcd_nibble_driver: each command is expanded into a per-cycle expected
// pin timeline from the strobe timing rules, then compared cycle by cycle.
module tb_lcd_nibble_driver;

   localparam int TS = 2;
   localparam int TH = 4;
   localparam int TL = 4;
   localparam int NP = 3;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       sendCommand;
   logic [3:0] commandToSend;
   logic       commandToSendRs;
   logic       read_busy;
   logic       commandDone;
   logic       busyTimeout;
   logic       LCD_E;
   logic       LCD_RS;
   logic       LCD_RW;
   logic [3:0] LCD_DB_OUT;
   logic       LCD_DB_OE;
   logic [3:0] LCD_DB_IN;

   typedef struct packed {
      logic       e;
      logic       rs;
      logic       chkRs;
      logic       rw;
      logic       oe;
      logic [3:0] db;
      logic       done;
      logic       sample;
      logic       bf;
   } step_t;

   step_t expQ[$];
   int    testCount = 0;
   int    failCount = 0;
   logic  expTimeout = 1'b0;
   logic  willTimeout = 1'b0;

   lcd_nibble_driver #(
      .T_SETUP(TS),
      .T_E_HIGH(TH),
      .T_E_LOW(TL),
      .BUSY_TIMEOUT_POLLS(NP)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .sendCommand(sendCommand),
      .commandToSend(commandToSend),
      .commandToSendRs(commandToSendRs),
      .read_busy(read_busy),
      .commandDone(commandDone),
      .busyTimeout(busyTimeout),
      .LCD_E(LCD_E),
      .LCD_RS(LCD_RS),
      .LCD_RW(LCD_RW),
      .LCD_DB_OUT(LCD_DB_OUT),
      .LCD_DB_OE(LCD_DB_OE),
      .LCD_DB_IN(LCD_DB_IN)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkNibble(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic pushSteps(input int n, input step_t s);
      for (int i = 0; i < n; i++) expQ.push_back(s);
   endtask

   // Expected pins for cycles 1..N after the accept edge.
   task automatic buildTimeline(input logic [3:0] nib, input logic rs, input logic rb,
                                input int busyCount);
      step_t s;
      int    polls;
      expQ.delete();
      willTimeout = 1'b0;
      s = '0;
      s.rs = rs; s.chkRs = 1'b1; s.oe = 1'b1; s.db = nib;
      pushSteps(TS, s);
      s.e = 1'b1; pushSteps(TH, s);
      s.e = 1'b0; pushSteps(TL, s);
      if (rb) begin
         s = '0;
         s.rw = 1'b1; s.chkRs = 1'b1;
         pushSteps(TS, s);
         polls = (busyCount >= NP) ? NP : busyCount + 1;
         for (int p = 0; p < polls; p++) begin
            s.e = 1'b1; s.bf = (p < busyCount); s.sample = 1'b0;
            pushSteps(TH - 1, s);
            s.sample = 1'b1; expQ.push_back(s);
            s.sample = 1'b0; s.e = 1'b0; pushSteps(TL, s);
            s.e = 1'b1; pushSteps(TH, s);
            s.e = 1'b0; pushSteps(TL, s);
         end
         willTimeout = (busyCount >= NP);
      end
      s = '0;
      s.done = 1'b1;
      expQ.push_back(s);
   endtask

   // Issues one request in the next cycle and checks every cycle through its DONE.
   task automatic applyStimulus(input logic [3:0] nib, input logic rs, input logic rb,
                                input int busyCount, input bit noise);
      step_t s;
      @(posedge CLK); #1;
      sendCommand     = 1'b1;
      commandToSend   = nib;
      commandToSendRs = rs;
      read_busy       = rb;
      buildTimeline(nib, rs, rb, busyCount);
      for (int k = 0; k < expQ.size(); k++) begin
         @(posedge CLK); #1;
         s = expQ[k];
         if (s.done) expTimeout = expTimeout | willTimeout;
         checkOutput($sformatf("E@%0d", k + 1), LCD_E, s.e);
         checkOutput($sformatf("RW@%0d", k + 1), LCD_RW, s.rw);
         checkOutput($sformatf("OE@%0d", k + 1), LCD_DB_OE, s.oe);
         checkOutput($sformatf("done@%0d", k + 1), commandDone, s.done);
         checkOutput($sformatf("timeout@%0d", k + 1), busyTimeout, expTimeout);
         if (s.chkRs) checkOutput($sformatf("RS@%0d", k + 1), LCD_RS, s.rs);
         if (s.oe) checkNibble($sformatf("DB@%0d", k + 1), LCD_DB_OUT, s.db);
         commandToSend   = 4'($urandom);
         commandToSendRs = 1'($urandom);
         read_busy       = 1'($urandom);
         sendCommand     = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (s.done && noise) sendCommand = 1'b1;
         LCD_DB_IN = 4'($urandom);
         if (s.sample) LCD_DB_IN[3] = s.bf;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         sendCommand = 1'b0;
         LCD_DB_IN   = 4'($urandom);
         checkOutput("idleE", LCD_E, 1'b0);
         checkOutput("idleRW", LCD_RW, 1'b0);
         checkOutput("idleOE", LCD_DB_OE, 1'b0);
         checkOutput("idleDone", commandDone, 1'b0);
         checkOutput("idleTimeout", busyTimeout, expTimeout);
      end
   endtask

   initial begin
      RESET_N = 1'b1;
      sendCommand = 1'b0; commandToSend = 4'h0; commandToSendRs = 1'b0;
      read_busy = 1'b0; LCD_DB_IN = 4'h0;
      #2 RESET_N = 1'b0;
      #2;
      checkOutput("rstE", LCD_E, 1'b0);
      checkOutput("rstRS", LCD_RS, 1'b0);
      checkOutput("rstRW", LCD_RW, 1'b0);
      checkNibble("rstDB", LCD_DB_OUT, 4'h0);
      checkOutput("rstOE", LCD_DB_OE, 1'b0);
      checkOutput("rstDone", commandDone, 1'b0);
      checkOutput("rstTimeout", busyTimeout, 1'b0);
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      idleCycles(2);

      // Directed: write-only, BF clear, busy once, busy up to the limit, stuck busy.
      applyStimulus(4'hA, 1'b1, 1'b0, 0, 1'b0);
      idleCycles(2);
      applyStimulus(4'h3, 1'b0, 1'b1, 0, 1'b0);
      idleCycles(1);
      applyStimulus(4'h6, 1'b1, 1'b1, 1, 1'b0);
      applyStimulus(4'hC, 1'b0, 1'b1, NP - 1, 1'b0);
      idleCycles(1);
      applyStimulus(4'h9, 1'b1, 1'b1, NP + 2, 1'b0);
      idleCycles(2);
      applyStimulus(4'h5, 1'b0, 1'b0, 0, 1'b1);

      // Random commands with ignored request pulses and back-to-back accepts.
      for (int n = 0; n < 40; n++) begin
         applyStimulus(4'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, NP + 1), 1'b1);
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
      end
      idleCycles(1);

      // Asynchronous reset in the middle of the E-high phase of a write.
      @(posedge CLK); #1;
      sendCommand = 1'b1; commandToSend = 4'hF; commandToSendRs = 1'b1; read_busy = 1'b1;
      @(posedge CLK); #1;
      sendCommand = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("preRstE", LCD_E, 1'b1);
      checkOutput("preRstOE", LCD_DB_OE, 1'b1);
      #2 RESET_N = 1'b0;
      #1;
      checkOutput("asyncRstE", LCD_E, 1'b0);
      checkOutput("asyncRstOE", LCD_DB_OE, 1'b0);
      checkOutput("asyncRstRS", LCD_RS, 1'b0);
      checkOutput("asyncRstTimeout", busyTimeout, 1'b0);
      expTimeout = 1'b0;
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      idleCycles(40);
      applyStimulus(4'h2, 1'b1, 1'b1, 0, 1'b0);
      idleCycles(2);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/lcd_nibble_driver.md
# lcd_nibble_driver

Physical-layer driver for an HD44780-compatible character LCD in 4-bit mode. It sits between the text/command sequencer and the LCD pins. Each request carries one nibble and its RS bit; the block generates the E strobe with setup, pulse-width and hold timing, and optionally polls the busy flag (BF) before reporting completion. It is the responder for the sequencer's `sendCommand`/`commandDone` handshake.

## Interface
- `T_SETUP`, 2: cycles that RS/RW/DB are stable with E low before E rises (≥1).
- `T_E_HIGH`, 25: cycles E is high per strobe (≥1).
- `T_E_LOW`, 25: cycles E is low after each strobe (hold plus cycle time, ≥1).
- `BUSY_TIMEOUT_POLLS`, 4096: maximum BF polls per command before giving up (≥1).
- `CLK` in 1: system clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `sendCommand` in 1: one-cycle request strobe, sampled only in IDLE.
- `commandToSend` in 4: nibble to write, latched on accept.
- `commandToSendRs` in 1: RS for the nibble, latched on accept.
- `read_busy` in 1: poll BF after this nibble, latched on accept.
- `commandDone` out 1: one-cycle completion pulse.
- `busyTimeout` out 1: sticky flag; set when BF polling hits the limit, cleared only by reset.
- `LCD_E`, `LCD_RS`, `LCD_RW` out 1 each: LCD control pins.
- `LCD_DB_OUT` out 4: drive value for DB7..DB4.
- `LCD_DB_OE` out 1: drive enable for DB7..DB4. The tristate buffer lives at top level.
- `LCD_DB_IN` in 4: sampled DB7..DB4. Bit 3 is DB7 (BF).

## Operation
- States: IDLE, W_SETUP, W_EHIGH, W_ELOW, R_SETUP, R1_EHIGH, R1_ELOW, R2_EHIGH, R2_ELOW, DONE.
- One down-counter times every state. Counter width is `$clog2` of the largest timing parameter. A separate poll counter is sized for `BUSY_TIMEOUT_POLLS`.
- IDLE: when `sendCommand` is high, latch the nibble, RS and `read_busy`, then go to W_SETUP. While not in IDLE, `sendCommand` is ignored; there is no queue.
- W_SETUP:
  - LCD_RS = latched RS, LCD_RW = 0, LCD_DB_OUT = nibble, LCD_DB_OE = 1, LCD_E = 0.
  - These values hold unchanged through W_EHIGH and W_ELOW.
- W_EHIGH: LCD_E = 1.
- W_ELOW: LCD_E = 0. On exit, go to R_SETUP if `read_busy` was latched, otherwise to DONE.
- R_SETUP:
  - LCD_RS = 0, LCD_RW = 1, LCD_DB_OE = 0, in the same cycle. E has been low for at least `T_E_LOW` cycles at this point.
  - Lasts `T_SETUP` cycles.
- R1_EHIGH: LCD_E = 1. Capture `LCD_DB_IN[3]` as BF on the last cycle of the state.
- R1_ELOW: LCD_E = 0.
- R2_EHIGH / R2_ELOW: second strobe for the low address nibble. Read data is discarded.
- On R2_ELOW exit, increment the poll count, then:
  - BF = 1 and count < `BUSY_TIMEOUT_POLLS`: go to R1_EHIGH. No new setup; RW stays 1.
  - BF = 1 and count = `BUSY_TIMEOUT_POLLS`: set `busyTimeout`, go to DONE.
  - BF = 0: go to DONE.
- DONE:
  - `commandDone` = 1 for this single cycle.
  - LCD_RW = 0 and LCD_DB_OE stays 0.
  - Clear the poll count, then go to IDLE.
- LCD_E never rises while RW or DB_OE is changing. RW and OE change only in cycles where E is low.

## Timing
- Reset values, asserted asynchronously even mid-strobe:
  - State IDLE, both counters 0.
  - LCD_E, LCD_RS, LCD_RW, LCD_DB_OUT, LCD_DB_OE, commandDone and busyTimeout all 0.
- Take the accept edge as cycle 0. Write-only: `commandDone` is high in cycle 1 + T_SETUP + T_E_HIGH + T_E_LOW.
- With `read_busy` and N polls: add T_SETUP + N·2·(T_E_HIGH + T_E_LOW).
- From DONE, a request is next accepted in the cycle after DONE, i.e. the earliest accept is DONE+1.
- All outputs are registered. `LCD_DB_IN` is used on a single sampling cycle; synchronizing it is the top level's responsibility.

## Structure
- `lcd_pkg` holds:
  - the state enum `lcd_drv_state_t`;
  - default timing localparams for a 50 MHz clock (`LCD_T_SETUP=2`, `LCD_T_E_HIGH=25`, `LCD_T_E_LOW=25`).
- No sub-module. The timer and poll counter are inline; a separate timer module is not warranted.

## Test plan
All tests use T_SETUP=2, T_E_HIGH=4, T_E_LOW=4, BUSY_TIMEOUT_POLLS=3.
- **Write-only:** `sendCommand` with nibble 4'hA, RS=1, `read_busy`=0.
  - E is high in cycles 3–6.
  - DB_OUT=A, RS=1, RW=0, OE=1 hold over cycles 1–10.
  - `commandDone` is high only in cycle 11.
- **BF clear:** `read_busy`=1 with DB_IN[3]=0.
  - RW=1 and OE=0 from cycle 11.
  - E is high in cycles 13–16 and 21–24.
  - `commandDone` is high in cycle 29; `busyTimeout`=0.
- **BF busy once:** DB_IN[3]=1 on the first poll, 0 on the second.
  - Exactly 4 E pulses after the write.
  - `commandDone` is high in cycle 45.
- **BF stuck:** DB_IN[3]=1 throughout.
  - 3 polls.
  - `busyTimeout` is set and `commandDone` is high in cycle 61.
  - `busyTimeout` stays 1 across later commands until reset.
- **Ignored requests:** `sendCommand` pulses during W_EHIGH and during DONE. They are ignored and there is no second `commandDone`. A pulse in DONE+1 is accepted.
- **Reset mid-operation:** `RESET_N` goes low during W_EHIGH.
  - LCD_E and OE drop immediately, with no clock edge needed.
  - After release, the block is in IDLE and `commandDone` never fires for the aborted command.
